// File: rtl/vga_timing_analyzer.sv
// Measures hsync/vsync period and pulse width from already-synchronised sync inputs
// and publishes them through a small byte-wide register file.
module vga_timing_analyzer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam logic [15:0] SAT = 16'hFFFF;

  logic        enable, h_invert, v_invert, freeze;
  logic        h_prev, v_prev;
  logic        h_seen, v_seen;
  logic [15:0] h_cnt, h_w, v_lines, v_w;
  logic [15:0] hperiod, hwidth, vperiod, vwidth;
  logic [7:0]  frame;
  logic        h_valid, v_valid, h_ovf, v_ovf;
  logic        h_asserted, v_asserted;
  logic        h_start, h_end, v_start, v_end;
  logic        ctrl_wr, clear;
  logic        unused_bits;

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == SAT) ? x : x + 16'd1;
  endfunction

  assign h_asserted  = ui_in[0] ^ h_invert;
  assign v_asserted  = ui_in[1] ^ v_invert;
  assign h_start     = h_asserted & ~h_prev;
  assign h_end       = ~h_asserted & h_prev;
  assign v_start     = v_asserted & ~v_prev;
  assign v_end       = ~v_asserted & v_prev;
  assign ctrl_wr     = data_write && (address == 4'h0);
  assign clear       = ctrl_wr && data_in[3];
  assign unused_bits = ^{ui_in[7:2], data_in[7:5]};

  // Control, edge history and the registered pin outputs; edge history runs even when disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      h_invert <= 1'b0;
      v_invert <= 1'b0;
      freeze   <= 1'b0;
      h_prev   <= 1'b0;
      v_prev   <= 1'b0;
      uo_out   <= 8'h00;
    end else begin
      h_prev <= h_asserted;
      v_prev <= v_asserted;
      uo_out <= {4'b0000, v_start & enable, h_start & enable, v_asserted, h_asserted};
      if (ctrl_wr) begin
        enable   <= data_in[0];
        h_invert <= data_in[1];
        v_invert <= data_in[2];
        freeze   <= data_in[4];
      end
    end
  end

  // Measurement counters and published results; a clear write overrides any update this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      h_seen  <= 1'b0;
      v_seen  <= 1'b0;
      h_cnt   <= 16'd0;
      h_w     <= 16'd0;
      v_lines <= 16'd0;
      v_w     <= 16'd0;
      hperiod <= 16'd0;
      hwidth  <= 16'd0;
      vperiod <= 16'd0;
      vwidth  <= 16'd0;
      frame   <= 8'd0;
      h_valid <= 1'b0;
      v_valid <= 1'b0;
      h_ovf   <= 1'b0;
      v_ovf   <= 1'b0;
    end else if (!enable) begin
      h_seen  <= 1'b0;
      v_seen  <= 1'b0;
      h_cnt   <= 16'd0;
      h_w     <= 16'd0;
      v_lines <= 16'd0;
      v_w     <= 16'd0;
    end else begin
      if (h_start) begin
        if (h_seen && !freeze) begin
          hperiod <= h_cnt;
          h_valid <= 1'b1;
        end
        h_cnt  <= 16'd1;
        h_w    <= 16'd1;
        h_seen <= 1'b1;
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (h_asserted) h_w <= sat_inc(h_w);
      end
      if (h_end && h_seen && !freeze) hwidth <= h_w;
      if (h_cnt == SAT || h_w == SAT) h_ovf <= 1'b1;

      // A line edge coinciding with the frame edge belongs to the new frame.
      if (v_start) begin
        if (v_seen && !freeze) begin
          vperiod <= v_lines;
          v_valid <= 1'b1;
          frame   <= frame + 8'd1;
        end
        v_lines <= {15'd0, h_start};
        v_w     <= {15'd0, h_start};
        v_seen  <= 1'b1;
      end else if (h_start) begin
        v_lines <= sat_inc(v_lines);
        if (v_asserted) v_w <= sat_inc(v_w);
      end
      if (v_end && v_seen && !freeze) vwidth <= v_w;
      if (v_lines == SAT || v_w == SAT) v_ovf <= 1'b1;
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0: data_out = {3'b000, freeze, 1'b0, v_invert, h_invert, enable};
      4'h1: data_out = {frame[3:0], v_ovf, h_ovf, v_valid, h_valid};
      4'h2: data_out = hperiod[7:0];
      4'h3: data_out = hperiod[15:8];
      4'h4: data_out = hwidth[7:0];
      4'h5: data_out = hwidth[15:8];
      4'h6: data_out = vperiod[7:0];
      4'h7: data_out = vperiod[15:8];
      4'h8: data_out = vwidth[7:0];
      4'h9: data_out = vwidth[15:8];
      4'hA: data_out = frame;
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_vga_timing_analyzer.sv
// Directed bench for vga_timing_analyzer: each task drives one scenario and checks
// register reads and pin outputs against hand-computed values.
module tb_vga_timing_analyzer;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  vga_timing_analyzer dut (
    .clk(clk),
    .rst_n(rst_n),
    .ui_in(ui_in),
    .uo_out(uo_out),
    .address(address),
    .data_write(data_write),
    .data_in(data_in),
    .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    data_in    = 8'h00;
    address    = 4'h0;
  endtask

  // Reads are combinational, so they take no clock edges.
  task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  // One hsync line: hi cycles high, then lo cycles low (raw pin level).
  task automatic hline(input int hi, input int lo);
    repeat (hi) begin ui_in[0] = 1'b1; @(negedge clk); end
    repeat (lo) begin ui_in[0] = 1'b0; @(negedge clk); end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst_n = 1'b0; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    wait_cycles(3);
    checks++;
    if (uo_out !== 8'h00) begin $display("FAIL reset_uo_out: got %h want 00", uo_out); errors++; end
    for (int a = 0; a < 16; a++) begin
      read_reg(a[3:0], v);
      checks++;
      if (v !== 8'h00) begin $display("FAIL reset_reg%0h: got %h want 00", a, v); errors++; end
    end
    rst_n = 1'b1;
    wait_cycles(1);
    read_reg(4'h0, v);
    checks++;
    if (v !== 8'h00 || uo_out !== 8'h00) begin
      $display("FAIL post_reset: ctrl %h uo_out %h want 00 00", v, uo_out); errors++;
    end
  endtask

  task automatic test_hperiod;
    logic [7:0] v;
    logic [7:0] exp [0:4];
    logic [3:0] adr [0:4];
    write_reg(4'h0, 8'h01);
    wait_cycles(2);
    hline(1, 0);
    checks++;
    if (uo_out !== 8'h05) begin $display("FAIL h_start_pulse: got %h want 05", uo_out); errors++; end
    hline(1, 0);
    checks++;
    if (uo_out !== 8'h01) begin $display("FAIL h_start_single: got %h want 01", uo_out); errors++; end
    hline(94, 704);
    hline(96, 704);
    hline(96, 704);
    adr = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h1};
    exp = '{8'h20, 8'h03, 8'h60, 8'h00, 8'h01};
    for (int i = 0; i < 5; i++) begin
      read_reg(adr[i], v);
      checks++;
      if (v !== exp[i]) begin $display("FAIL hperiod_reg%0h: got %h want %h", adr[i], v, exp[i]); errors++; end
    end
  endtask

  // Continues straight from the last line, so the single start republishes 800.
  task automatic test_overflow;
    logic [7:0] v;
    logic [7:0] exp [0:3];
    logic [3:0] adr [0:3];
    hline(70000, 0);
    adr = '{4'h1, 4'h2, 4'h3, 4'h4};
    exp = '{8'h05, 8'h20, 8'h03, 8'h60};
    for (int i = 0; i < 4; i++) begin
      read_reg(adr[i], v);
      checks++;
      if (v !== exp[i]) begin $display("FAIL ovf_reg%0h: got %h want %h", adr[i], v, exp[i]); errors++; end
    end
    write_reg(4'h0, 8'h09);
    read_reg(4'h1, v);
    checks++;
    if (v !== 8'h00) begin $display("FAIL ovf_cleared_status: got %h want 00", v); errors++; end
    hline(0, 10);
  endtask

  task automatic test_freeze;
    logic [7:0] v;
    hline(96, 704);
    hline(96, 704);
    hline(96, 704);
    write_reg(4'h0, 8'h11);
    hline(96, 904);
    hline(96, 904);
    hline(96, 903);
    read_reg(4'h2, v);
    checks++;
    if (v !== 8'h20) begin $display("FAIL frozen_hperiod_lo: got %h want 20", v); errors++; end
    read_reg(4'h3, v);
    checks++;
    if (v !== 8'h03) begin $display("FAIL frozen_hperiod_hi: got %h want 03", v); errors++; end
    write_reg(4'h0, 8'h01);
    hline(96, 904);
    read_reg(4'h2, v);
    checks++;
    if (v !== 8'hE8) begin $display("FAIL unfrozen_hperiod_lo: got %h want e8", v); errors++; end
    read_reg(4'h3, v);
    checks++;
    if (v !== 8'h03) begin $display("FAIL unfrozen_hperiod_hi: got %h want 03", v); errors++; end
    read_reg(4'h4, v);
    checks++;
    if (v !== 8'h60) begin $display("FAIL unfrozen_hwidth_lo: got %h want 60", v); errors++; end
  endtask

  // 525-line frames with inverted syncs; lines shortened to 8 clocks to bound run time.
  task automatic test_vsync;
    logic [7:0] v;
    logic [7:0] exp [0:10];
    logic [3:0] adr [0:10];
    ui_in[1:0] = 2'b11;
    write_reg(4'h0, 8'h08);
    write_reg(4'h0, 8'h07);
    wait_cycles(2);
    for (int l = 0; l < 530; l++) begin
      for (int p = 0; p < 8; p++) begin
        ui_in[0] = (p >= 2);
        ui_in[1] = ((l % 525) >= 2);
        @(negedge clk);
      end
    end
    adr = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h0};
    exp = '{8'h13, 8'h08, 8'h00, 8'h02, 8'h00, 8'h0D, 8'h02, 8'h02, 8'h00, 8'h01, 8'h07};
    for (int i = 0; i < 11; i++) begin
      read_reg(adr[i], v);
      checks++;
      if (v !== exp[i]) begin $display("FAIL vsync_reg%0h: got %h want %h", adr[i], v, exp[i]); errors++; end
    end
  endtask

  task automatic test_clear;
    logic [7:0] v;
    write_reg(4'h0, 8'h09);
    for (int a = 0; a < 11; a++) begin
      read_reg(a[3:0], v);
      checks++;
      if (v !== ((a == 0) ? 8'h01 : 8'h00)) begin
        $display("FAIL clear_reg%0h: got %h want %h", a, v, (a == 0) ? 8'h01 : 8'h00); errors++;
      end
    end
    write_reg(4'h1, 8'hFF);
    write_reg(4'hC, 8'hAA);
    read_reg(4'h1, v);
    checks++;
    if (v !== 8'h00) begin $display("FAIL ro_write_status: got %h want 00", v); errors++; end
    read_reg(4'hC, v);
    checks++;
    if (v !== 8'h00) begin $display("FAIL ro_write_regc: got %h want 00", v); errors++; end
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    ui_in[1:0] = 2'b00;
    hline(0, 5);
    hline(96, 704);
    hline(96, 704);
    hline(40, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (uo_out !== 8'h00) begin $display("FAIL midreset_uo_out: got %h want 00", uo_out); errors++; end
    for (int a = 0; a < 16; a++) begin
      read_reg(a[3:0], v);
      checks++;
      if (v !== 8'h00) begin $display("FAIL midreset_reg%0h: got %h want 00", a, v); errors++; end
    end
    rst_n = 1'b1;
    write_reg(4'h0, 8'h01);
    hline(20, 30);
    read_reg(4'h4, v);
    checks++;
    if (v !== 8'h00) begin $display("FAIL postreset_hwidth: got %h want 00", v); errors++; end
    read_reg(4'h2, v);
    checks++;
    if (v !== 8'h00) begin $display("FAIL postreset_hperiod: got %h want 00", v); errors++; end
    read_reg(4'h1, v);
    checks++;
    if (v !== 8'h00) begin $display("FAIL postreset_status: got %h want 00", v); errors++; end
    checks++;
    if (uo_out !== 8'h00) begin $display("FAIL postreset_uo_out: got %h want 00", uo_out); errors++; end
  endtask

  initial begin
    test_reset();
    test_hperiod();
    test_overflow();
    test_freeze();
    test_vsync();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
